// File: rtl/scan_reg_bank.sv
// rtl/scan_reg_bank.sv - scannable register bank with functional load, clear/preset and auto-shift
//
// Ports:
//   C            in   clock; active edge selected by CLK_POL
//   global_reset in   asynchronous active-high reset to RESET_VALUE / IDLE
//   D            in   functional data
//   CE           in   functional load enable
//   CLR          in   synchronous clear (highest priority, also aborts auto-shift)
//   PRE          in   synchronous preset to all-ones
//   NbarT        in   manual scan shift, one bit per active edge
//   Si           in   scan input, enters at the MSB
//   scan_start   in   request an auto-shift of exactly WIDTH bits
//   Q            out  register contents
//   So           out  scan output, Q[0]
//   busy         out  auto-shift in progress
//   done         out  one-cycle pulse after a completed auto-shift

module scan_reg_bank #(
    parameter int                 WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter bit                 CLK_POL     = 1'b1
) (
    input  logic             C,
    input  logic             global_reset,
    input  logic [WIDTH-1:0] D,
    input  logic             CE,
    input  logic             CLR,
    input  logic             PRE,
    input  logic             NbarT,
    input  logic             Si,
    input  logic             scan_start,
    output logic [WIDTH-1:0] Q,
    output logic             So,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_en;

    // Shifting comes either from the auto-shift controller or from manual
    // scan mode; both move exactly one bit per edge.
    assign shift_en = (state_q == SHIFT) || NbarT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // The start edge only arms the controller; the first shift
                // happens on the following edge.
                if (scan_start && !CLR) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Counter advances even when PRE overrides the shift, so the
                // auto-shift always spans exactly WIDTH edges.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear aborts any auto-shift without producing a done pulse.
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (PRE) begin
            q_d = '1;
        end else if (shift_en) begin
            q_d = {Si, q_q[WIDTH-1:1]};
        end else if (CE) begin
            q_d = D;
        end
    end

    // Edge selection is fixed at elaboration; reset stays asynchronous and
    // active-high regardless of clock polarity.
    generate
        if (CLK_POL) begin : g_rise
            always_ff @(posedge C or posedge global_reset) begin
                if (global_reset) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    q_q     <= RESET_VALUE;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    q_q     <= q_d;
                end
            end
        end else begin : g_fall
            always_ff @(negedge C or posedge global_reset) begin
                if (global_reset) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    q_q     <= RESET_VALUE;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    q_q     <= q_d;
                end
            end
        end
    endgenerate

    assign Q    = q_q;
    assign So   = q_q[0];
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_scan_reg_bank.sv
// tb/tb_scan_reg_bank.sv - self-checking bench for scan_reg_bank (rising and falling edge instances)

module tb_scan_reg_bank;

    logic       C;
    logic       rst   [2];
    logic [7:0] d     [2];
    logic       ce    [2];
    logic       clr   [2];
    logic       pre   [2];
    logic       nbart [2];
    logic       si    [2];
    logic       ss    [2];
    logic [7:0] q     [2];
    logic       so    [2];
    logic       busy  [2];
    logic       done  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Index 1: rising-edge instance, index 0: falling-edge instance.
    scan_reg_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .CLK_POL(1'b1)) dut_r (
        .C(C), .global_reset(rst[1]), .D(d[1]), .CE(ce[1]), .CLR(clr[1]),
        .PRE(pre[1]), .NbarT(nbart[1]), .Si(si[1]), .scan_start(ss[1]),
        .Q(q[1]), .So(so[1]), .busy(busy[1]), .done(done[1])
    );

    scan_reg_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .CLK_POL(1'b0)) dut_f (
        .C(C), .global_reset(rst[0]), .D(d[0]), .CE(ce[0]), .CLR(clr[0]),
        .PRE(pre[0]), .NbarT(nbart[0]), .Si(si[0]), .scan_start(ss[0]),
        .Q(q[0]), .So(so[0]), .busy(busy[0]), .done(done[0])
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-shift count instead of a state machine.
    logic [7:0] mq    [2];
    int         left  [2];
    bit         mbusy [2];
    bit         mdone [2];

    task automatic model_reset(input int p);
        mq[p]    = 8'hA5;
        left[p]  = 0;
        mbusy[p] = 1'b0;
        mdone[p] = 1'b0;
    endtask

    task automatic model_edge(input int p);
        bit shifting;
        shifting = mbusy[p] || nbart[p];
        if (clr[p]) begin
            mq[p]    = 8'h00;
            left[p]  = 0;
            mbusy[p] = 1'b0;
            mdone[p] = 1'b0;
        end else begin
            if (mdone[p]) begin
                mdone[p] = 1'b0;
            end else if (mbusy[p]) begin
                left[p] = left[p] - 1;
                if (left[p] == 0) begin
                    mbusy[p] = 1'b0;
                    mdone[p] = 1'b1;
                end
            end else if (ss[p]) begin
                mbusy[p] = 1'b1;
                left[p]  = 8;
            end
            if (pre[p])        mq[p] = 8'hFF;
            else if (shifting) mq[p] = {si[p], mq[p][7:1]};
            else if (ce[p])    mq[p] = d[p];
        end
    endtask

    always @(posedge C or posedge rst[1]) begin
        if (rst[1]) model_reset(1);
        else        model_edge(1);
    end

    always @(negedge C or posedge rst[0]) begin
        if (rst[0]) model_reset(0);
        else        model_edge(0);
    end

    // Compare both instances shortly after every clock transition; the
    // inactive edge of each instance must leave it unchanged.
    always @(C) begin
        #2;
        if (rst[0] === 1'b0 && rst[1] === 1'b0) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("model_q[%0d]", p), q[p], mq[p]);
                check($sformatf("model_so[%0d]", p), 8'(so[p]), 8'(mq[p][0]));
                check($sformatf("model_busy[%0d]", p), 8'(busy[p]), 8'(mbusy[p]));
                check($sformatf("model_done[%0d]", p), 8'(done[p]), 8'(mdone[p]));
            end
        end
    end

    task automatic tick(input int p);
        if (p == 1) @(posedge C);
        else        @(negedge C);
        #3;
    endtask

    task automatic run(input int p);
        logic [7:0] si_bits;
        logic [7:0] so_exp;
        si_bits = 8'b0100_1101;  // stream 1,0,1,1,0,0,1,0 read LSB first
        so_exp  = 8'h3C;         // So sequence 0,0,1,1,1,1,0,0 read LSB first

        // Load
        d[p] = 8'h3C; ce[p] = 1'b1;
        tick(p);
        ce[p] = 1'b0;
        check($sformatf("load[%0d]", p), q[p], 8'h3C);

        // Asynchronous reset between edges
        rst[p] = 1'b1;
        #1;
        check($sformatf("rst_q[%0d]", p), q[p], 8'hA5);
        check($sformatf("rst_so[%0d]", p), 8'(so[p]), 8'h01);
        check($sformatf("rst_busy[%0d]", p), 8'(busy[p]), 8'h00);
        check($sformatf("rst_done[%0d]", p), 8'(done[p]), 8'h00);
        rst[p] = 1'b0;

        // Priority: CLR over PRE over CE, then PRE over CE
        clr[p] = 1'b1; pre[p] = 1'b1; ce[p] = 1'b1; d[p] = 8'hFF;
        tick(p);
        check($sformatf("clr_prio[%0d]", p), q[p], 8'h00);
        clr[p] = 1'b0;
        tick(p);
        check($sformatf("pre_prio[%0d]", p), q[p], 8'hFF);
        pre[p] = 1'b0;
        d[p] = 8'h3C;
        tick(p);
        ce[p] = 1'b0;
        check($sformatf("reload[%0d]", p), q[p], 8'h3C);

        // Auto-shift
        ss[p] = 1'b1;
        tick(p);
        ss[p] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            si[p] = si_bits[i];
            ss[p] = (i == 3);
            check($sformatf("as_so%0d[%0d]", i, p), 8'(so[p]), 8'(so_exp[i]));
            check($sformatf("as_busy%0d[%0d]", i, p), 8'(busy[p]), 8'h01);
            tick(p);
        end
        ss[p] = 1'b0;
        check($sformatf("as_done[%0d]", p), 8'(done[p]), 8'h01);
        check($sformatf("as_busy_end[%0d]", p), 8'(busy[p]), 8'h00);
        check($sformatf("as_q[%0d]", p), q[p], 8'h4D);
        tick(p);
        check($sformatf("as_done_drop[%0d]", p), 8'(done[p]), 8'h00);

        // Abort with CLR on the third shift
        si[p] = 1'b1;
        ss[p] = 1'b1;
        tick(p);
        ss[p] = 1'b0;
        tick(p);
        tick(p);
        clr[p] = 1'b1;
        tick(p);
        clr[p] = 1'b0;
        check($sformatf("abort_q[%0d]", p), q[p], 8'h00);
        check($sformatf("abort_busy[%0d]", p), 8'(busy[p]), 8'h00);
        check($sformatf("abort_done[%0d]", p), 8'(done[p]), 8'h00);
        tick(p);
        check($sformatf("abort_nodone[%0d]", p), 8'(done[p]), 8'h00);
        ss[p] = 1'b1;
        tick(p);
        ss[p] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("re_busy%0d[%0d]", i, p), 8'(busy[p]), 8'h01);
            tick(p);
        end
        check($sformatf("re_done[%0d]", p), 8'(done[p]), 8'h01);
        check($sformatf("re_q[%0d]", p), q[p], 8'hFF);
        tick(p);

        // Reset during the fifth shift, then manual shifting
        si[p] = 1'b0;
        ss[p] = 1'b1;
        tick(p);
        ss[p] = 1'b0;
        for (int i = 0; i < 4; i++) tick(p);
        rst[p] = 1'b1;
        #1;
        check($sformatf("mid_rst_q[%0d]", p), q[p], 8'hA5);
        check($sformatf("mid_rst_busy[%0d]", p), 8'(busy[p]), 8'h00);
        check($sformatf("mid_rst_done[%0d]", p), 8'(done[p]), 8'h00);
        rst[p] = 1'b0;
        nbart[p] = 1'b1; si[p] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(p);
            check($sformatf("man_busy%0d[%0d]", i, p), 8'(busy[p]), 8'h00);
            check($sformatf("man_done%0d[%0d]", i, p), 8'(done[p]), 8'h00);
        end
        check($sformatf("man_q[%0d]", p), q[p], 8'hFF);
        nbart[p] = 1'b0; si[p] = 1'b0;
        tick(p);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rst[p] = 1'b1; d[p] = 8'h00; ce[p] = 1'b0; clr[p] = 1'b0;
            pre[p] = 1'b0; nbart[p] = 1'b0; si[p] = 1'b0; ss[p] = 1'b0;
        end
        #13;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        run(1);
        run(0);
        tick(1);
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
